// File: rtl/rect_fill_gen.sv
`default_nettype none
// ============================================================================
//  Module   : rect_fill_gen
//  Purpose  : Accepts one rectangle request (two corners + color), normalizes
//             and clips it to the screen, then streams one pixel-write word per
//             covered pixel in raster order to the DrawUnit FIFO write port.
//             Stalls while the FIFO reports full.
//  Ports    : clk, reset (async, active-low)
//             start, x0, x1, y0, y1, color  - request (taken when ready=1)
//             abort                         - cancel fill in progress
//             ready, done                   - idle flag / completion pulse
//             we, data, full                - FIFO write port, data={color,y,x}
//  Revision : 1.0 - initial release
// ============================================================================
module rect_fill_gen #(
    parameter int XW   = 10,
    parameter int YW   = 9,
    parameter int CW   = 3,
    parameter int XMAX = 639,
    parameter int YMAX = 479
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [XW-1:0]        x0,
    input  logic [XW-1:0]        x1,
    input  logic [YW-1:0]        y0,
    input  logic [YW-1:0]        y1,
    input  logic [CW-1:0]        color,
    input  logic                 abort,
    output logic                 ready,
    output logic                 done,
    output logic                 we,
    output logic [CW+YW+XW-1:0]  data,
    input  logic                 full
);

    localparam logic [XW-1:0] XMAX_V = XW'(XMAX);
    localparam logic [YW-1:0] YMAX_V = YW'(YMAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x0_q, x0_d, x1_q, x1_d;
    logic [YW-1:0]   y0_q, y0_d, y1_q, y1_d;
    logic [CW-1:0]   col_q, col_d;
    logic [XW-1:0]   xl_q, xl_d, xh_q, xh_d, xc_q, xc_d;
    logic [YW-1:0]   yh_q, yh_d, yc_q, yc_d;

    // Normalized and clipped bounds derived from the latched corners
    logic [XW-1:0]   x_lo, x_hi, x_hi_clip;
    logic [YW-1:0]   y_lo, y_hi, y_hi_clip;

    always_comb begin
        x_lo      = (x0_q < x1_q) ? x0_q : x1_q;
        x_hi      = (x0_q < x1_q) ? x1_q : x0_q;
        y_lo      = (y0_q < y1_q) ? y0_q : y1_q;
        y_hi      = (y0_q < y1_q) ? y1_q : y0_q;
        x_hi_clip = (x_hi > XMAX_V) ? XMAX_V : x_hi;
        y_hi_clip = (y_hi > YMAX_V) ? YMAX_V : y_hi;
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        col_d   = col_q;
        xl_d    = xl_q;
        xh_d    = xh_q;
        yh_d    = yh_q;
        xc_d    = xc_q;
        yc_d    = yc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    x1_d    = x1;
                    y0_d    = y0;
                    y1_d    = y1;
                    col_d   = color;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // Only the low bound can fall off-screen; the clipped high
                // bound is then never below the low bound.
                if ((x_lo > XMAX_V) || (y_lo > YMAX_V)) begin
                    state_d = S_FIN;
                end else begin
                    xl_d    = x_lo;
                    xh_d    = x_hi_clip;
                    yh_d    = y_hi_clip;
                    xc_d    = x_lo;
                    yc_d    = y_lo;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                // Abort wins over a write in the same cycle
                if (abort) begin
                    state_d = S_FIN;
                end else if (!full) begin
                    if (xc_q < xh_q) begin
                        xc_d = xc_q + 1'b1;
                    end else begin
                        xc_d = xl_q;
                        yc_d = yc_q + 1'b1;
                        if (yc_q == yh_q) begin
                            state_d = S_FIN;
                        end
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        ready = (state_q == S_IDLE);
        done  = (state_q == S_FIN);
        we    = (state_q == S_FILL) && !full && !abort;
        data  = {col_q, yc_q, xc_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            col_q   <= '0;
            xl_q    <= '0;
            xh_q    <= '0;
            yh_q    <= '0;
            xc_q    <= '0;
            yc_q    <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            col_q   <= col_d;
            xl_q    <= xl_d;
            xh_q    <= xh_d;
            yh_q    <= yh_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rect_fill_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rect_fill_gen
//  Purpose  : Self-checking bench for rect_fill_gen. Directed vector table,
//             hand-written multi-cycle sequences and randomized requests,
//             all compared against a raster-order reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rect_fill_gen;

    localparam int LIMIT = 600;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  x0, x1;
    logic [8:0]  y0, y1;
    logic [2:0]  color;
    logic        abort;
    logic        ready;
    logic        done;
    logic        we;
    logic [21:0] data;
    logic        full;

    rect_fill_gen #(
        .XW(10), .YW(9), .CW(3), .XMAX(639), .YMAX(479)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
        .abort(abort), .ready(ready), .done(done), .we(we),
        .data(data), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [21:0] got_q[$];
    logic [21:0] exp_q[$];
    logic [21:0] stall_q[$];
    int done_c, ready_c, last_w_c, n_done, stall_we;

    typedef struct {
        int x0, x1, y0, y1, col;
        int exp_n;
        int exp_done;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [21:0] word(input int c, input int y, input int x);
        word = 22'((c << 19) | (y << 10) | x);
    endfunction

    // Reference: every on-screen pixel of the normalized rectangle, row by row
    function automatic void model(input int ax0, input int ax1, input int ay0,
                                  input int ay1, input int acol);
        int xl, xh, yl, yh;
        exp_q.delete();
        xl = (ax0 < ax1) ? ax0 : ax1;
        xh = (ax0 < ax1) ? ax1 : ax0;
        yl = (ay0 < ay1) ? ay0 : ay1;
        yh = (ay0 < ay1) ? ay1 : ay0;
        if (xh > 639) xh = 639;
        if (yh > 479) yh = 479;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                exp_q.push_back(word(acol, y, x));
    endfunction

    // Issue one request and follow it until ready returns. Cycle c=1 is the
    // cycle right after the edge that samples start.
    task automatic run_req(input int ax0, input int ax1, input int ay0, input int ay1,
                           input int acol, input int full_pct, input int abort_after,
                           input int stall_after, input bit busy_start);
        int c;
        int stalls;
        got_q.delete();
        stall_q.delete();
        done_c = -1; ready_c = -1; last_w_c = -1; n_done = 0; stall_we = 0;
        stalls = 0;
        @(posedge clk); #1;
        x0 = 10'(ax0); x1 = 10'(ax1); y0 = 9'(ay0); y1 = 9'(ay1); color = 3'(acol);
        start = 1'b1; full = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        for (int g = 0; g < LIMIT; g++) begin
            full  = (full_pct > 0) && ($urandom_range(99) < full_pct);
            abort = (abort_after >= 0) && (got_q.size() == abort_after);
            if (stall_after >= 0 && got_q.size() == stall_after && stalls < 3) begin
                full = 1'b1;
                stalls++;
            end
            if (busy_start && c == 3) begin
                start = 1'b1; x0 = 10'd0; x1 = 10'd20; y0 = 9'd0; y1 = 9'd20; color = 3'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (full && stall_after >= 0 && got_q.size() == stall_after) begin
                stall_q.push_back(data);
                if (we) stall_we++;
            end
            if (we) begin
                got_q.push_back(data);
                last_w_c = c;
            end
            if (done) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            if (ready && c > 1) begin
                ready_c = c;
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        full = 1'b0; abort = 1'b0; start = 1'b0;
        if (ready_c < 0) chk("timeout", 0, 1);
    endtask

    // Common checks: write stream vs model, one done right after last write,
    // ready the cycle after done.
    task automatic chk_req(input string name, input int exp_done);
        chk({name, " nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({name, " word"}, got_q[i], exp_q[i]);
        chk({name, " ndone"}, n_done, 1);
        if (exp_done >= 0)          chk({name, " done_cycle"}, done_c, exp_done);
        else if (exp_q.size() == 0) chk({name, " done_cycle"}, done_c, 2);
        else                        chk({name, " done_cycle"}, done_c, last_w_c + 1);
        chk({name, " ready_cycle"}, ready_c, done_c + 1);
    endtask

    vec_t vecs[8];

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; full = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;

        vecs[0] = '{2,    4,   10,  11,  5, 6, 8};
        vecs[1] = '{645,  637, 479, 478, 1, 6, 8};
        vecs[2] = '{700,  800, 5,   6,   2, 0, 2};
        vecs[3] = '{7,    7,   7,   7,   3, 1, 3};
        vecs[4] = '{9,    0,   3,   3,   6, 10, 12};
        vecs[5] = '{639,  639, 0,   4,   4, 5, 7};
        vecs[6] = '{10,   12,  480, 500, 7, 0, 2};
        vecs[7] = '{1023, 639, 511, 479, 0, 1, 3};

        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", ready, 1);
        chk("reset done", done, 0);
        chk("reset we", we, 0);
        chk("reset data", data, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle data", data, 0);

        // Directed table, no backpressure
        foreach (vecs[i]) begin
            model(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].col);
            chk("vec model count", exp_q.size(), vecs[i].exp_n);
            run_req(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].col, 0, -1, -1, 1'b0);
            chk_req($sformatf("vec%0d", i), vecs[i].exp_done);
        end

        // Backpressure: 3 stall cycles after the second write
        model(0, 3, 0, 0, 2);
        run_req(0, 3, 0, 0, 2, 0, -1, 2, 1'b0);
        chk_req("stall", -1);
        chk("stall cycles", stall_q.size(), 3);
        chk("stall we", stall_we, 0);
        foreach (stall_q[i]) chk("stall data", stall_q[i], word(2, 0, 2));
        chk("stall last write", last_w_c, 8);

        // Abort after the 15th write of a 10x10 fill
        model(20, 29, 30, 39, 3);
        run_req(20, 29, 30, 39, 3, 0, 15, -1, 1'b0);
        chk("abort nwrites", got_q.size(), 15);
        for (int i = 0; i < got_q.size() && i < 15; i++) chk("abort word", got_q[i], exp_q[i]);
        chk("abort ndone", n_done, 1);
        chk("abort done_cycle", done_c, last_w_c + 2);
        chk("abort ready_cycle", ready_c, done_c + 1);
        model(5, 6, 7, 8, 4);
        run_req(5, 6, 7, 8, 4, 0, -1, -1, 1'b0);
        chk_req("post-abort", 6);

        // Start while busy must be dropped
        model(50, 52, 60, 61, 6);
        run_req(50, 52, 60, 61, 6, 0, -1, -1, 1'b1);
        chk_req("busy", 8);
        begin
            int extra = 0;
            repeat (10) begin
                @(negedge clk);
                if (we || !ready) extra++;
            end
            chk("busy dropped", extra, 0);
        end

        // Reset mid-fill
        @(posedge clk); #1;
        x0 = 10'd100; x1 = 10'd109; y0 = 9'd100; y1 = 9'd109; color = 3'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre-reset we", we, 1);
        reset = 1'b0;
        #1;
        chk("rst we", we, 0);
        chk("rst done", done, 0);
        chk("rst ready", ready, 1);
        chk("rst data", data, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        begin
            int extra = 0;
            repeat (25) begin
                @(negedge clk);
                if (we || done || !ready) extra++;
            end
            chk("post-reset quiet", extra, 0);
        end

        // Randomized requests near the clip corner and near the origin
        for (int r = 0; r < 40; r++) begin
            int ax0, ax1, ay0, ay1, acol, tmp;
            if (r % 2 == 0) begin
                ax0 = $urandom_range(655, 625);
                ay0 = $urandom_range(495, 465);
            end else begin
                ax0 = $urandom_range(20, 0);
                ay0 = $urandom_range(20, 0);
            end
            ax1 = ax0 + $urandom_range(6, 0);
            ay1 = ay0 + $urandom_range(5, 0);
            if ($urandom_range(1, 0) == 1) begin tmp = ax0; ax0 = ax1; ax1 = tmp; end
            if ($urandom_range(1, 0) == 1) begin tmp = ay0; ay0 = ay1; ay1 = tmp; end
            acol = $urandom_range(7, 0);
            model(ax0, ax1, ay0, ay1, acol);
            run_req(ax0, ax1, ay0, ay1, acol, 30, -1, -1, 1'b0);
            chk_req($sformatf("rand%0d", r), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/rect_fill_gen.md
# rect_fill_gen

Rectangle fill generator that sits directly upstream of the DrawUnit pixel FIFO. It accepts one rectangle request (two corners plus a 3-bit color), normalizes and clips it to the 640x480 screen, then emits one pixel-write word per covered pixel on DrawUnit's `we`/`data`/`full` write port, in raster order. It stalls whenever the FIFO reports `full`.

## Interface
- `XW`, default 10: x coordinate width.
- `YW`, default 9: y coordinate width.
- `CW`, default 3: color width; matches DrawUnit `color2`.
- `XMAX`, default 639: last visible column.
- `YMAX`, default 479: last visible row.

Ports:
- `clk`, in, 1: single clock, shared with DrawUnit's write side.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request strobe; accepted only when `ready`=1.
- `x0`, `x1`, in, XW each: corner columns, in any order.
- `y0`, `y1`, in, YW each: corner rows, in any order.
- `color`, in, CW: fill color.
- `abort`, in, 1: cancels the fill in progress.
- `ready`, out, 1: high in IDLE.
- `done`, out, 1: one-cycle pulse when a request completes or is aborted.
- `we`, out, 1: write strobe to DrawUnit.
- `data`, out, CW+YW+XW: pixel word `{color, y, x}`, with x in the LSBs.
- `full`, in, 1: DrawUnit FIFO full.

## Operation
- States:
  - IDLE → SETUP on `start`.
  - SETUP → FILL, or → FIN if the clipped rectangle is empty.
  - FILL → FIN after the last pixel, or on `abort`.
  - FIN → IDLE.
- IDLE: `ready`=1. On `start`, latch all inputs; `start` is ignored in every other state.
- SETUP (exactly one cycle):
  - Normalize: `xl`=min(x0,x1), `xh`=max(x0,x1); same for y.
  - Clip: `xh`=min(`xh`,XMAX), `yh`=min(`yh`,YMAX).
  - Empty if `xl`>XMAX or `yl`>YMAX; otherwise load `xc`=`xl`, `yc`=`yl`.
- FILL:
  - `we` = !`full` (combinational from `full`); `data` = {`col`, `yc`, `xc`}.
  - On each cycle with `we`=1: if `xc`<`xh`, increment `xc`. Otherwise set `xc`=`xl` and increment `yc`.
  - The write at `xc`==`xh` and `yc`==`yh` is the last one; move to FIN.
- `abort` in FILL takes priority over any write: `we`=0 that cycle and the next state is FIN. `abort` in any other state is ignored.
- FIN: `done`=1 for one cycle, `we`=0; then IDLE.
- Degenerate requests: a single pixel (x0=x1, y0=y1) produces one write. A one-row or one-column rectangle is valid.
- Counters never wrap, because comparisons use clipped bounds. Arithmetic is unsigned, at XW/YW width.

## Timing
- Reset values: state=IDLE, `ready`=1, `done`=0, `we`=0, `data`=0, all internal registers 0.
- `reset` asserted mid-fill: return to IDLE immediately. No `done` pulse, and the partial fill is not resumed.
- `start` sampled at edge N → SETUP during cycle N+1 → first `we` possible in cycle N+2.
- With `full` held low: a W×H rectangle gives W·H consecutive `we` cycles, `done` in the cycle after the last write, and `ready` one cycle later. Start-to-ready is W·H+3 cycles.
- Empty rectangle: `done` in cycle N+2, zero writes.
- `full` high: `we`=0 that same cycle, and counters and `data` hold. Throughput is one pixel per non-full cycle.
- `data` is stable whenever `we` is high and changes only after an accepted write.

## Test plan
- Basic fill: start with x0=2, x1=4, y0=10, y1=11, color=5, `full`=0. Expect 6 writes, in order (2,10), (3,10), (4,10), (2,11), (3,11), (4,11), every word with color 5. Expect `done` one cycle after the last write and `ready` again 9 cycles after the `start` edge.
- Swapped corners and clipping: x0=645, x1=637, y0=479, y1=478, color=1. Expect writes at x 637..639 on rows 478 and 479 only, 6 writes total. Also x0=700, x1=800: zero writes and `done` 2 cycles after `start`.
- Backpressure: 1×4 rectangle at (0,0)..(3,0). Hold `full` high for 3 cycles after the second write. Expect `we`=0 with `data` held at (2,0) during the stall, then 2 more writes. Total of 4 writes, no duplicates, none skipped.
- Abort: 10×10 fill. Assert `abort` after the 15th write. Expect no further `we`, `done` on the next cycle, then `ready`. A new `start` then fills normally.
- Start ignored while busy: pulse `start` with different coordinates during FILL. Expect the first rectangle to complete unchanged and the second request to be dropped.
- Reset mid-fill: drop `reset` low for 1 cycle during FILL. Expect `we`=0, `done`=0, `ready`=1, `data`=0 immediately, and no writes after release.
